eq_1bit: RTL and testbench



---
 rtl/eq1_pkg.sv | 14 +
 rtl/eq1_sat_counter.sv | 23 ++
 rtl/eq_1bit.sv | 79 +++++++
 tb/tb_eq_1bit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/eq1_pkg.sv
// Shared defaults and the saturating-increment helper for the eq_1bit comparator.
package eq1_pkg;

    localparam int EQ1_CNT_W_DEF      = 8;
    localparam int EQ1_HIST_DEPTH_DEF = 8;

    // Increment, but hold once the low 'width' bits are all ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/eq1_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module eq1_sat_counter
    import eq1_pkg::*;
#(
    parameter int W = EQ1_CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= W'(sat_inc(32'(cnt), W));
    end

endmodule

// File: rtl/eq_1bit.sv
// Registered 1-bit equality checker with sticky mismatch flag and saturating counters.
// Define EQ1_HISTORY_EN to add the result history shift register and its port.
module eq_1bit
    import eq1_pkg::*;
#(
    parameter int CNT_W      = EQ1_CNT_W_DEF,
    parameter int HIST_DEPTH = EQ1_HIST_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             b1,
    input  logic             b2,
    input  logic             in_valid,
    input  logic             clear,
    output logic             out,
    output logic             out_valid,
    output logic             mismatch_sticky,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
`ifdef EQ1_HISTORY_EN
    ,
    output logic [HIST_DEPTH-1:0] history
`endif
);

    logic res;
    assign res = ~(b1 ^ b2);

    // out holds across idle cycles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out <= res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mismatch_sticky <= 1'b0;
        else if (clear)
            mismatch_sticky <= 1'b0;
        else if (in_valid && !res)
            mismatch_sticky <= 1'b1;
    end

    eq1_sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid & res),
        .clr   (clear),
        .cnt   (match_cnt)
    );

    eq1_sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid & ~res),
        .clr   (clear),
        .cnt   (mismatch_cnt)
    );

`ifdef EQ1_HISTORY_EN
    // Shift form keeps HIST_DEPTH=1 legal; clear deliberately leaves history alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            history <= '0;
        else if (in_valid)
            history <= (history << 1) | HIST_DEPTH'(res);
    end
`else
    logic [HIST_DEPTH-1:0] unused_hist;
    assign unused_hist = '0;
`endif

endmodule

// File: tb/tb_eq_1bit.sv
// Randomized self-checking bench for eq_1bit: two instances (CNT_W=8 and CNT_W=2) against a behavioural model.
module tb_eq_1bit;

    localparam int HD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b1 = 1'b0, b2 = 1'b0, in_valid = 1'b0, clear = 1'b0;

    logic       o8, v8, s8, o2, v2, s2;
    logic [7:0] mc8, mm8;
    logic [1:0] mc2, mm2;
`ifdef EQ1_HISTORY_EN
    logic [HD-1:0] h8, h2;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_out = 0, m_vld = 0, m_st = 0;
    int m_mc8 = 0, m_mm8 = 0, m_mc2 = 0, m_mm2 = 0;
    int m_hist = 0;

    always #5 clk = ~clk;

    eq_1bit #(.CNT_W(8), .HIST_DEPTH(HD)) dut8 (
        .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .in_valid(in_valid), .clear(clear),
        .out(o8), .out_valid(v8), .mismatch_sticky(s8), .match_cnt(mc8), .mismatch_cnt(mm8)
`ifdef EQ1_HISTORY_EN
        , .history(h8)
`endif
    );

    eq_1bit #(.CNT_W(2), .HIST_DEPTH(HD)) dut2 (
        .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .in_valid(in_valid), .clear(clear),
        .out(o2), .out_valid(v2), .mismatch_sticky(s2), .match_cnt(mc2), .mismatch_cnt(mm2)
`ifdef EQ1_HISTORY_EN
        , .history(h2)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int eq;
        if (!rst_n) begin
            m_out = 0; m_vld = 0; m_st = 0;
            m_mc8 = 0; m_mm8 = 0; m_mc2 = 0; m_mm2 = 0; m_hist = 0;
        end else begin
            eq = (in_valid && b1 == b2) ? 1 : 0;
            m_vld = in_valid ? 1 : 0;
            if (in_valid) begin
                m_out  = eq;
                m_hist = ((m_hist * 2) + eq) % (1 << HD);
            end
            if (clear) begin
                m_st = 0; m_mc8 = 0; m_mm8 = 0; m_mc2 = 0; m_mm2 = 0;
            end else if (in_valid) begin
                if (eq == 1) begin
                    m_mc8 = sat(m_mc8, 255); m_mc2 = sat(m_mc2, 3);
                end else begin
                    m_mm8 = sat(m_mm8, 255); m_mm2 = sat(m_mm2, 3);
                    m_st  = 1;
                end
            end
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        chk("out8", int'(o8), m_out);     chk("out2", int'(o2), m_out);
        chk("vld8", int'(v8), m_vld);     chk("vld2", int'(v2), m_vld);
        chk("sticky8", int'(s8), m_st);   chk("sticky2", int'(s2), m_st);
        chk("match8", int'(mc8), m_mc8);  chk("mism8", int'(mm8), m_mm8);
        chk("match2", int'(mc2), m_mc2);  chk("mism2", int'(mm2), m_mm2);
`ifdef EQ1_HISTORY_EN
        chk("hist8", int'(h8), m_hist);   chk("hist2", int'(h2), m_hist);
`endif
    end

    // Inputs change 2 time units after the rising edge; values sampled at the next edge.
    task automatic drive(input logic v, input logic a, input logic b, input logic c);
        in_valid = v; clear = c;
        b1 = v ? a : 1'bx;
        b2 = v ? b : 1'bx;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with a valid equal sample present
        rst_n = 1'b0; in_valid = 1'b1; b1 = 1'b0; b2 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out", int'(o8), 0);
        chk("rst_vld", int'(v8), 0);
        chk("rst_cnt", int'(mc8), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk("post_rst_vld", int'(v8), 0);

        // Truth table
        drive(1, 0, 0, 0); chk("tt00", int'(o8), 1); chk("tt00_vld", int'(v8), 1);
        drive(1, 0, 1, 0); chk("tt01", int'(o8), 0);
        drive(1, 1, 0, 0); chk("tt10", int'(o8), 0);
        drive(1, 1, 1, 0); chk("tt11", int'(o8), 1);
        chk("tt_match", int'(mc8), 2);
        chk("tt_mism", int'(mm8), 2);
        chk("tt_sticky", int'(s8), 1);

        // Hold with in_valid low and X on the operands
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            chk("hold_out", int'(o8), 1);
            chk("hold_vld", int'(v8), 0);
            chk("hold_match", int'(mc8), 2);
        end

        // Saturation of the 2-bit counter
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, i[0], i[0], 0);
        chk("sat_match2", int'(mc2), 3);
        chk("sat_match8", int'(mc8), 5);
        chk("sat_mism2", int'(mm2), 0);
        chk("sat_sticky", int'(s2), 0);
        drive(1, 1, 1, 0);
        chk("sat_hold2", int'(mc2), 3);

        // Clear colliding with a valid mismatch
        drive(1, 0, 1, 1);
        chk("clr_match", int'(mc8), 0);
        chk("clr_mism", int'(mm8), 0);
        chk("clr_sticky", int'(s8), 0);
        chk("clr_out", int'(o8), 0);
        chk("clr_vld", int'(v8), 1);

        // Async reset mid-stream, checked before any further edge
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
        chk("pre_rst_mism", int'(mm8), 3);
        rst_n = 1'b0;
        #1;
        chk("arst_mism", int'(mm8), 0);
        chk("arst_sticky", int'(s8), 0);
        chk("arst_vld", int'(v8), 0);
`ifdef EQ1_HISTORY_EN
        chk("arst_hist", int'(h8), 0);
`endif
        #1 rst_n = 1'b1;
        drive(1, 1, 1, 0);
        chk("first_after_rst", int'(mc8), 1);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            logic v, a, b, c;
            v = ($urandom_range(0, 3) != 0);
            a = 1'($urandom);
            b = ($urandom_range(0, 2) == 0) ? ~a : a;
            c = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            drive(v, a, b, c);
        end

        drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
